// File: rtl/alu_writeback.sv
// Commit stage: 2-entry ALU result FIFO, 16x32 register file, N/Z/C flags, r15 write strobe.
// Optional same-cycle read forwarding enabled by defining WB_BYPASS_EN.
module alu_writeback #(
    parameter int DW   = 32,
    parameter int NREG = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [3:0]    alu_rd_idx,
    input  logic [DW-1:0] alu_res,
    input  logic          alu_S,
    input  logic          alu_c,
    input  logic          alu_z,
    input  logic          alu_n,
    input  logic          ldr_wr_en,
    input  logic [3:0]    ldr_wr_idx,
    input  logic [DW-1:0] ldr_wr_data,
    input  logic [3:0]    rn_idx,
    input  logic [3:0]    rm_idx,
    output logic [DW-1:0] rn_data,
    output logic [DW-1:0] rm_data,
    output logic          carry_flag,
    output logic          zero_flag,
    output logic          neg_flag,
    output logic          pc_wr,
    output logic [DW-1:0] pc_wr_data,
    output logic          busy
);

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;
    localparam logic [3:0] PC_IDX    = 4'hF;

    logic [DW-1:0] regs [NREG];

    logic [3:0]    fifo_idx [2];
    logic [DW-1:0] fifo_res [2];
    logic [3:0]    fifo_fl  [2];   // {S, n, z, c}
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;

    logic          push;
    logic          pop;
    logic [3:0]    head_idx;
    logic [DW-1:0] head_res;
    logic [3:0]    head_fl;

    assign alu_ready = (count != CNT_FULL);
    assign busy      = (count != CNT_EMPTY);
    assign push      = alu_valid && alu_ready;
    assign pop       = busy && !ldr_wr_en;
    assign head_idx  = fifo_idx[rd_ptr];
    assign head_res  = fifo_res[rd_ptr];
    assign head_fl   = fifo_fl[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= CNT_EMPTY;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_idx[i] <= '0;
                fifo_res[i] <= '0;
                fifo_fl[i]  <= '0;
            end
        end else begin
            if (push) begin
                fifo_idx[wr_ptr] <= alu_rd_idx;
                fifo_res[wr_ptr] <= alu_res;
                fifo_fl[wr_ptr]  <= {alu_S, alu_n, alu_z, alu_c};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= (count == CNT_EMPTY) ? CNT_ONE : CNT_FULL;
            end else if (pop && !push) begin
                count <= (count == CNT_FULL) ? CNT_ONE : CNT_EMPTY;
            end
        end
    end

    // Load port wins; a stalled ALU head retries next cycle so its value lands last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (ldr_wr_en) begin
            regs[ldr_wr_idx] <= ldr_wr_data;
        end else if (pop) begin
            regs[head_idx] <= head_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_flag   <= 1'b0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else if (pop && head_fl[3]) begin
            neg_flag   <= head_fl[2];
            zero_flag  <= head_fl[1];
            carry_flag <= head_fl[0];
        end
    end

    always_comb begin
        pc_wr      = 1'b0;
        pc_wr_data = '0;
        if (ldr_wr_en && (ldr_wr_idx == PC_IDX)) begin
            pc_wr      = 1'b1;
            pc_wr_data = ldr_wr_data;
        end else if (pop && (head_idx == PC_IDX)) begin
            pc_wr      = 1'b1;
            pc_wr_data = head_res;
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        rn_data = regs[rn_idx];
        if (ldr_wr_en && (ldr_wr_idx == rn_idx)) begin
            rn_data = ldr_wr_data;
        end else if (pop && (head_idx == rn_idx)) begin
            rn_data = head_res;
        end
    end

    always_comb begin
        rm_data = regs[rm_idx];
        if (ldr_wr_en && (ldr_wr_idx == rm_idx)) begin
            rm_data = ldr_wr_data;
        end else if (pop && (head_idx == rm_idx)) begin
            rm_data = head_res;
        end
    end
`else
    assign rn_data = regs[rn_idx];
    assign rm_data = regs[rm_idx];
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: vector table plus hand sequences for bypass and reset.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_rd_idx;
    logic [31:0] alu_res;
    logic        alu_S, alu_c, alu_z, alu_n;
    logic        ldr_wr_en;
    logic [3:0]  ldr_wr_idx;
    logic [31:0] ldr_wr_data;
    logic [3:0]  rn_idx, rm_idx;
    logic [31:0] rn_data, rm_data;
    logic        carry_flag, zero_flag, neg_flag;
    logic        pc_wr;
    logic [31:0] pc_wr_data;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    alu_writeback #(.DW(32), .NREG(16)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd_idx(alu_rd_idx), .alu_res(alu_res),
        .alu_S(alu_S), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n),
        .ldr_wr_en(ldr_wr_en), .ldr_wr_idx(ldr_wr_idx), .ldr_wr_data(ldr_wr_data),
        .rn_idx(rn_idx), .rm_idx(rm_idx), .rn_data(rn_data), .rm_data(rm_data),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .neg_flag(neg_flag),
        .pc_wr(pc_wr), .pc_wr_data(pc_wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        v;
        logic [3:0]  idx;
        logic [31:0] res;
        logic [3:0]  szcn;   // {S, n, z, c}
        logic        le;
        logic [3:0]  li;
        logic [31:0] ld;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic        e_rdy;
        logic        e_busy;
        logic [31:0] e_rn;
        logic [31:0] e_rm;
        logic [2:0]  e_fl;   // {N, Z, C}
        logic        e_pw;
        logic [31:0] e_pd;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(logic v, logic [3:0] idx, logic [31:0] res, logic [3:0] szcn,
                                logic le, logic [3:0] li, logic [31:0] ld,
                                logic [3:0] rn, logic [3:0] rm,
                                logic e_rdy, logic e_busy, logic [31:0] e_rn, logic [31:0] e_rm,
                                logic [2:0] e_fl, logic e_pw, logic [31:0] e_pd);
        vec_t t;
        t.v = v; t.idx = idx; t.res = res; t.szcn = szcn;
        t.le = le; t.li = li; t.ld = ld; t.rn = rn; t.rm = rm;
        t.e_rdy = e_rdy; t.e_busy = e_busy; t.e_rn = e_rn; t.e_rm = e_rm;
        t.e_fl = e_fl; t.e_pw = e_pw; t.e_pd = e_pd;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd_idx = 0; alu_res = 0;
        alu_S = 0; alu_c = 0; alu_z = 0; alu_n = 0;
        ldr_wr_en = 0; ldr_wr_idx = 0; ldr_wr_data = 0;
    endtask

    task automatic apply(input vec_t t);
        alu_valid = t.v; alu_rd_idx = t.idx; alu_res = t.res;
        {alu_S, alu_n, alu_z, alu_c} = t.szcn;
        ldr_wr_en = t.le; ldr_wr_idx = t.li; ldr_wr_data = t.ld;
        rn_idx = t.rn; rm_idx = t.rm;
    endtask

    task automatic check_vec(input int n, input vec_t t);
        string s;
        s = $sformatf("v%0d", n);
        check({s, ".alu_ready"}, 32'(alu_ready), 32'(t.e_rdy));
        check({s, ".busy"}, 32'(busy), 32'(t.e_busy));
        check({s, ".rn_data"}, rn_data, t.e_rn);
        check({s, ".rm_data"}, rm_data, t.e_rm);
        check({s, ".flags"}, 32'({neg_flag, zero_flag, carry_flag}), 32'(t.e_fl));
        check({s, ".pc_wr"}, 32'(pc_wr), 32'(t.e_pw));
        check({s, ".pc_wr_data"}, pc_wr_data, t.e_pd);
    endtask

    initial begin
        //              v idx  res        SNZC   le li  ld     rn  rm   rdy bsy e_rn   e_rm  NZC  pw pd
        vecs[0]  = mk(1, 3,  32'hF0,   4'b1001, 0, 0,  0,     3,  0,   1,  0,  0,     0,    3'b000, 0, 0);
        vecs[1]  = mk(0, 0,  0,        4'b0000, 0, 0,  0,     1,  0,   1,  1,  0,     0,    3'b000, 0, 0);
        vecs[2]  = mk(0, 0,  0,        4'b0000, 0, 0,  0,     3,  3,   1,  0,  32'hF0, 32'hF0, 3'b001, 0, 0);
        vecs[3]  = mk(1, 7,  32'h70,   4'b0000, 1, 4,  32'hA, 2,  2,   1,  0,  0,     0,    3'b001, 0, 0);
        vecs[4]  = mk(1, 8,  32'h80,   4'b0000, 1, 5,  32'hB, 4,  0,   1,  1,  32'hA, 0,    3'b001, 0, 0);
        vecs[5]  = mk(1, 9,  32'h90,   4'b0000, 1, 6,  32'hC, 5,  7,   0,  1,  32'hB, 0,    3'b001, 0, 0);
        vecs[6]  = mk(1, 9,  32'h90,   4'b0000, 0, 0,  0,     6,  8,   0,  1,  32'hC, 0,    3'b001, 0, 0);
        vecs[7]  = mk(1, 9,  32'h90,   4'b0000, 0, 0,  0,     7,  9,   1,  1,  32'h70, 0,   3'b001, 0, 0);
        vecs[8]  = mk(0, 0,  0,        4'b0000, 0, 0,  0,     8,  7,   1,  1,  32'h80, 32'h70, 3'b001, 0, 0);
        vecs[9]  = mk(0, 0,  0,        4'b0000, 0, 0,  0,     9,  3,   1,  0,  32'h90, 32'hF0, 3'b001, 0, 0);
        vecs[10] = mk(1, 2,  32'h2222, 4'b0110, 0, 0,  0,     2,  0,   1,  0,  0,     0,    3'b001, 0, 0);
        vecs[11] = mk(0, 0,  0,        4'b0000, 1, 2,  32'h1111, 3, 0, 1,  1,  32'hF0, 0,   3'b001, 0, 0);
        vecs[12] = mk(0, 0,  0,        4'b0000, 0, 0,  0,     2,  4,   1,  1,  (BYP ? 32'h2222 : 32'h1111), 32'hA, 3'b001, 0, 0);
        vecs[13] = mk(0, 0,  0,        4'b0000, 0, 0,  0,     2,  0,   1,  0,  32'h2222, 0, 3'b001, 0, 0);
        vecs[14] = mk(1, 15, 32'h100,  4'b1010, 0, 0,  0,     0,  0,   1,  0,  0,     0,    3'b001, 0, 0);
        vecs[15] = mk(0, 0,  0,        4'b0000, 0, 0,  0,     1,  1,   1,  1,  0,     0,    3'b001, 1, 32'h100);
        vecs[16] = mk(0, 0,  0,        4'b0000, 0, 0,  0,     15, 0,   1,  0,  32'h100, 0,  3'b010, 0, 0);
        vecs[17] = mk(0, 0,  0,        4'b0000, 1, 15, 32'h200, 0, 0,  1,  0,  0,     0,    3'b010, 1, 32'h200);
        vecs[18] = mk(0, 0,  0,        4'b0000, 0, 0,  0,     15, 3,   1,  0,  32'h200, 32'hF0, 3'b010, 0, 0);

        idle();
        rn_idx = 0; rm_idx = 0;
        rst = 1'b1;
        #1;
        check("reset.alu_ready", 32'(alu_ready), 32'd1);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.pc_wr", 32'(pc_wr), 32'd0);
        check("reset.pc_wr_data", pc_wr_data, 32'd0);
        check("reset.flags", 32'({neg_flag, zero_flag, carry_flag}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check_vec(i, vecs[i]);
        end

        // Forwarding of an ALU commit to r5 (currently 0xB)
        @(negedge clk);
        idle();
        alu_valid = 1; alu_rd_idx = 5; alu_res = 32'hDEAD;
        rn_idx = 5; rm_idx = 0;
        #1 check("byp.pre", rn_data, 32'hB);
        @(negedge clk);
        idle();
        #1 check("byp.alu_commit", rn_data, BYP ? 32'hDEAD : 32'hB);
        @(negedge clk);
        #1 check("byp.after", rn_data, 32'hDEAD);
        // Forwarding of a load write to r6 (currently 0xC)
        @(negedge clk);
        ldr_wr_en = 1; ldr_wr_idx = 6; ldr_wr_data = 32'h1234;
        rn_idx = 6; rm_idx = 6;
        #1 check("byp.ldr_rn", rn_data, BYP ? 32'h1234 : 32'hC);
        check("byp.ldr_rm", rm_data, BYP ? 32'h1234 : 32'hC);
        @(negedge clk);
        idle();
        #1 check("byp.ldr_after", rn_data, 32'h1234);

        // Reset mid-run with the FIFO full
        @(negedge clk);
        ldr_wr_en = 1; ldr_wr_idx = 11; ldr_wr_data = 32'h55;
        alu_valid = 1; alu_rd_idx = 10; alu_res = 32'h1;
        @(negedge clk);
        alu_rd_idx = 12; alu_res = 32'h2;
        @(negedge clk);
        alu_valid = 0;
        rn_idx = 3; rm_idx = 11;
        #1 check("rstmid.full", 32'(alu_ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("rstmid.alu_ready", 32'(alu_ready), 32'd1);
        check("rstmid.busy", 32'(busy), 32'd0);
        check("rstmid.r3", rn_data, 32'd0);
        check("rstmid.r11", rm_data, 32'd0);
        check("rstmid.flags", 32'({neg_flag, zero_flag, carry_flag}), 32'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        rn_idx = 10; rm_idx = 12;
        repeat (2) @(negedge clk);
        #1;
        check("rstpost.busy", 32'(busy), 32'd0);
        check("rstpost.r10", rn_data, 32'd0);
        check("rstpost.r12", rm_data, 32'd0);
        check("rstpost.pc_wr", 32'(pc_wr), 32'd0);
        check("rstpost.flags", 32'({neg_flag, zero_flag, carry_flag}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
